// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, opcodes and immediate helpers for the fetch stage
package fetch_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } fetch_entry_t;

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two decoupling FIFO with flush, count and head
module fetch_fifo #(
  parameter int  QDEPTH = 4,
  parameter type T      = logic
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  T                        i_data,
  output T                        o_head,
  output logic [$clog2(QDEPTH):0] o_count
);

  localparam int PW = $clog2(QDEPTH);

  T                r_mem [QDEPTH];
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [PW:0]     r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left uncleared; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - PC, instruction ROM and next-PC logic feeding the fetch FIFO; optional FETCH_STATIC_PREDICT_EN
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                      NUM_INST = 128,
  parameter int                      QDEPTH   = 4,
  parameter logic [31:0]             RESET_PC = 32'h0000_0000,
  parameter logic [NUM_INST*32-1:0]  MEM_INIT = '0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dec_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fd_valid,
  output logic [63:0] fetch_dec_reg,
  output logic        fd_pred_taken
);

  localparam int AW = $clog2(NUM_INST);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]   r_pc;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_instr;
  logic [31:0]   w_next_pc;
  logic          w_pred;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_entry;
  fetch_entry_t  w_head;

  // Upper PC bits are dropped so out-of-range addresses alias into the ROM.
  assign w_idx   = r_pc[AW+1:2];
  assign w_instr = MEM_INIT[{w_idx, 5'b00000} +: 32];

`ifdef FETCH_STATIC_PREDICT_EN
  always_comb begin
    w_pred    = 1'b0;
    w_next_pc = r_pc + 32'd4;
    if (w_instr[6:0] == OPC_JAL) begin
      w_pred    = 1'b1;
      w_next_pc = r_pc + imm_j(w_instr);
    end else if (w_instr[6:0] == OPC_BRANCH && w_instr[31]) begin
      w_pred    = 1'b1;
      w_next_pc = r_pc + imm_b(w_instr);
    end
  end
`else
  assign w_pred    = 1'b0;
  assign w_next_pc = r_pc + 32'd4;
`endif

  assign w_pop  = fd_valid & dec_ready;
  assign w_push = !redirect_valid & ((w_count < CW'(QDEPTH)) | w_pop);

  assign w_entry.instr = w_instr;
  assign w_entry.pc    = r_pc;
  assign w_entry.pred  = w_pred;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
    end else if (w_push) begin
      r_pc <= w_next_pc;
    end
  end

  fetch_fifo #(
    .QDEPTH (QDEPTH),
    .T      (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign fd_valid      = (w_count != '0);
  assign fetch_dec_reg = fd_valid ? {w_head.instr, w_head.pc} : 64'd0;
  assign fd_pred_taken = fd_valid & w_head.pred;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - directed bench for fetch_queue_unit
module tb_fetch_queue_unit;

  localparam int NI = 128;

`ifdef FETCH_STATIC_PREDICT_EN
  localparam logic PRED_EN = 1'b1;
`else
  localparam logic PRED_EN = 1'b0;
`endif

  // Word 8 (0x20) is beq x0,x0,-16; word 24 (0x60) is beq x0,x0,+8; the rest are unique addi x0 words.
  function automatic logic [31:0] mem_word(input int k);
    if (k == 8)  return 32'hFE00_08E3;
    if (k == 24) return 32'h0000_0463;
    return (32'(k) << 20) | 32'h0000_0013;
  endfunction

  function automatic logic [NI*32-1:0] mk_mem();
    logic [NI*32-1:0] m;
    m = '0;
    for (int k = 0; k < NI; k++) m[k*32 +: 32] = mem_word(k);
    return m;
  endfunction

  localparam logic [NI*32-1:0] MEM = mk_mem();

  logic        clk = 1'b0;
  logic        rstn;
  logic        dec_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fd_valid;
  logic [63:0] fetch_dec_reg;
  logic        fd_pred_taken;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .NUM_INST (NI),
    .QDEPTH   (4),
    .RESET_PC (32'h0000_0000),
    .MEM_INIT (MEM)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .dec_ready      (dec_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fd_valid       (fd_valid),
    .fetch_dec_reg  (fetch_dec_reg),
    .fd_pred_taken  (fd_pred_taken)
  );

  function automatic logic [31:0] mem_at(input logic [31:0] pc);
    return mem_word(int'((pc >> 2) % NI));
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, 64'(fd_valid), 64'd0);
    chk({tag, ".reg"}, fetch_dec_reg, 64'd0);
    chk({tag, ".pred"}, 64'(fd_pred_taken), 64'd0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic pred);
    chk({tag, ".valid"}, 64'(fd_valid), 64'd1);
    chk({tag, ".reg"}, fetch_dec_reg, {mem_at(pc), pc});
    chk({tag, ".pred"}, 64'(fd_pred_taken), 64'(pred));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rstn           = 1'b0;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    @(negedge clk);
    tick(1);
    chk_empty("reset");

    // Reset release with decode stalled: fill to QDEPTH, then pc freezes at 0x10.
    rstn = 1'b1;
    tick(1);
    chk_head("first_fetch", 32'h0, 1'b0);
    tick(9);
    chk_head("full_hold", 32'h0, 1'b0);

    dec_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk_head($sformatf("drain_%0d", i), 32'(i * 4), 1'b0);
    end

    // Redirect with a full queue to an out-of-range PC: aliases to word 0.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    dec_ready      = 1'b0;
    tick(1);
    chk_empty("redir_wrap_bubble");
    redirect_valid = 1'b0;
    tick(1);
    chk_head("wrap", 32'h200, 1'b0);
    tick(2);
    chk_head("hold3", 32'h200, 1'b0);

    // Redirect to an unaligned target with three entries queued and a same-cycle pop.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    dec_ready      = 1'b1;
    tick(1);
    chk_empty("redir_bubble");
    redirect_valid = 1'b0;
    tick(1);
    chk_head("redir_head", 32'h40, 1'b0);
    tick(1);
    chk_head("redir_next", 32'h44, 1'b0);

    // Backward branch at 0x20.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0020;
    tick(1);
    redirect_valid = 1'b0;
    tick(1);
    chk_head("bwd_br", 32'h20, PRED_EN);
    tick(1);
    chk_head("bwd_next", PRED_EN ? 32'h10 : 32'h24, 1'b0);

    // Forward branch at 0x60 is never predicted taken.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0060;
    tick(1);
    redirect_valid = 1'b0;
    tick(1);
    chk_head("fwd_br", 32'h60, 1'b0);
    tick(1);
    chk_head("fwd_next", 32'h64, 1'b0);

    // Asynchronous reset with a full queue, between clock edges.
    dec_ready = 1'b0;
    tick(5);
    chk_head("full2", 32'h64, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk_empty("async_reset");
    @(negedge clk);
    rstn      = 1'b1;
    dec_ready = 1'b1;
    tick(1);
    chk_head("restart", 32'h0, 1'b0);
    tick(1);
    chk_head("restart_next", 32'h4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch stage with a decoupling queue between instruction memory and decode. Each cycle it reads one 32-bit instruction at the current PC and pushes {instruction, pc} into a QDEPTH-entry FIFO. Decode pops entries through a valid/ready handshake. A redirect from execute flushes the queue and restarts fetch at the new PC. It replaces the single-register fetch stage, which had no stall handling.

## Interface
- NUM_INST, 128: instruction memory depth in 32-bit words; power of two.
- QDEPTH, 4: fetch queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: PC loaded on reset; word aligned.
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- dec_ready  in  1  decode accepts the head entry this cycle.
- redirect_valid  in  1  execute resolved a mispredict, taken branch or jump.
- redirect_pc  in  32  target PC for the redirect.
- fd_valid  out  1  fetch_dec_reg holds a valid entry.
- fetch_dec_reg  out  64  {instruction[63:32], pc[31:0]} of the queue head; 0 when empty.
- fd_pred_taken  out  1  head entry was predicted taken. Tied 0 without FETCH_STATIC_PREDICT_EN.

## Operation
- State: pc register; FIFO with read pointer, write pointer and count (0..QDEPTH).
- Memory read: combinational. Index = pc[$clog2(NUM_INST)+1:2], so out-of-range PCs wrap modulo NUM_INST. pc[1:0] is ignored.
- pop = fd_valid & dec_ready.
- push = !redirect_valid & (count < QDEPTH | pop). On push, write {instr, pc, pred} and set pc <= next_pc.
- next_pc = pc + 4, or the predicted target (see Configuration).
- Full without pop: no push; pc holds.
- Simultaneous push and pop: both happen, count unchanged. This is legal at full and at empty with count 1.
- Redirect has priority over everything else in its cycle:
  - all entries invalidated, count <= 0;
  - pc <= {redirect_pc[31:2], 2'b00};
  - no push;
  - a pop in the same cycle still counts as consumed by decode.
- Outputs are driven from the head entry. When count = 0: fd_valid = 0, fetch_dec_reg = 0, fd_pred_taken = 0.
- Arithmetic: 32-bit PC addition, wraps at 2^32 with no flag.
- Reset (asynchronous, mid-operation included): pc <= RESET_PC, pointers and count <= 0, all outputs 0 immediately. Queue storage need not be cleared.

## Timing
- Fetch to visible: an entry pushed at edge N is at the head, with fd_valid = 1, after edge N if the queue was empty. Otherwise it appears after the older entries drain.
- First fetch after rstn deasserts: first rising edge pushes RESET_PC; fd_valid = 1 from that edge.
- Steady state with dec_ready = 1: one entry per cycle, PCs consecutive, no bubbles.
- Redirect at edge R: fd_valid = 0 after R. The redirect_pc entry is pushed at R+1 and is visible after R+1, giving a 1-cycle bubble.
- dec_ready = 0 held: queue fills after QDEPTH edges (minus the initial count), then pc freezes.

## Configuration
- FETCH_STATIC_PREDICT_EN defined: static prediction on the fetched instruction.
  - JAL (opcode 1101111): next_pc = pc + J-immediate, pred = 1.
  - B-type (opcode 1100011) with imm[12] = 1 (backward branch): next_pc = pc + B-immediate, pred = 1.
  - All other instructions: next_pc = pc + 4, pred = 0.
  - Execute must redirect to pc+4 on a wrong prediction.
- Not defined: next_pc = pc + 4 always; fd_pred_taken tied 0; no predictor logic synthesised.

## Structure
- Shared package fetch_pkg:
  - fetch_entry_t packed struct {instr, pc, pred};
  - opcode constants OPC_JAL, OPC_BRANCH;
  - immediate-extract functions for J-type and B-type.
- Sub-module fetch_fifo, parametrised by QDEPTH and entry type, with push, pop, flush, count, head. The top level holds pc, the memory array and next-PC logic.

## Test plan
- Reset release with dec_ready = 1, memory of NOPs → fd_valid high after edge 1; pc sequence 0x0, 0x4, 0x8, … on successive cycles.
- dec_ready = 0 for 10 cycles, QDEPTH = 4 → count saturates at 4 and pc holds at 0x10. On dec_ready = 1, entries 0x0..0xC drain, then 0x10 follows with no gap.
- Redirect to 0x40 while the queue holds 3 entries → next cycle fd_valid = 0; following cycle head pc = 0x40. Stale entries never appear.
- Redirect to 0x43 → head pc = 0x40. PC 0x200 with NUM_INST = 128 → instruction returned from word 0.
- With FETCH_STATIC_PREDICT_EN: at 0x20, beq with offset -16 → next head pc = 0x10 with fd_pred_taken = 1. A forward beq → pc 0x24, pred 0. Without the macro → pc 0x24 in both cases.
- Assert rstn low mid-stream with a full queue → fd_valid and fetch_dec_reg drop to 0 without waiting for a clock edge; after release, fetch resumes at RESET_PC.
